// File: rtl/cclimb_pkg.sv
// cclimb_pkg: shared FSM states, ROM region map and region one-hot codes for the ROM loader
package cclimb_pkg;
    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_DONE, ST_ERROR} state_t;
    localparam int RGN_W = 6;
    typedef logic [RGN_W-1:0] region_t;
    localparam logic [15:0] CPU_BASE  = 16'h0000;
    localparam logic [15:0] CPU_LIM   = 16'h5FFF;
    localparam logic [15:0] BG_BASE   = 16'h6000;
    localparam logic [15:0] BG_LIM    = 16'h6FFF;
    localparam logic [15:0] SPR_BASE  = 16'h7000;
    localparam logic [15:0] SPR_LIM   = 16'h7FFF;
    localparam logic [15:0] BIG_BASE  = 16'h8000;
    localparam logic [15:0] BIG_LIM   = 16'h87FF;
    localparam logic [15:0] SMP_BASE  = 16'h8800;
    localparam logic [15:0] SMP_LIM   = 16'h8FFF;
    localparam logic [15:0] PROM_BASE = 16'h9000;
    localparam logic [15:0] PROM_LIM  = 16'h905F;
    localparam region_t RGN_NONE = 6'b000000;
    localparam region_t RGN_CPU  = 6'b000001;
    localparam region_t RGN_BG   = 6'b000010;
    localparam region_t RGN_SPR  = 6'b000100;
    localparam region_t RGN_BIG  = 6'b001000;
    localparam region_t RGN_SMP  = 6'b010000;
    localparam region_t RGN_PROM = 6'b100000;
    // unsigned offset test avoids a ">= 0" compare for the region starting at zero
    function automatic logic in_rgn(input logic [15:0] a, input logic [15:0] base, input logic [15:0] lim);
        return (a - base) <= (lim - base);
    endfunction
endpackage

// File: rtl/cclimb_rom_loader_if.sv
// cclimb_rom_loader_if: HPS ioctl download bus in, registered core ROM write port out
interface cclimb_rom_loader_if;
    logic        ioctl_download;
    logic        ioctl_wr;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;
    logic [15:0] dn_addr;
    logic [7:0]  dn_data;
    logic        dn_wr;
    logic [5:0]  dn_region;
    modport master (
        output ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout,
        input  dn_addr, dn_data, dn_wr, dn_region
    );
    modport slave (
        input  ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout,
        output dn_addr, dn_data, dn_wr, dn_region
    );
endinterface

// File: rtl/cclimb_region_dec.sv
// cclimb_region_dec: combinational byte address to one-hot ROM region decode
module cclimb_region_dec import cclimb_pkg::*; (
    input  logic [15:0] i_addr,
    output region_t     o_region
);
    assign o_region = in_rgn(i_addr, CPU_BASE,  CPU_LIM)  ? RGN_CPU  :
                      in_rgn(i_addr, BG_BASE,   BG_LIM)   ? RGN_BG   :
                      in_rgn(i_addr, SPR_BASE,  SPR_LIM)  ? RGN_SPR  :
                      in_rgn(i_addr, BIG_BASE,  BIG_LIM)  ? RGN_BIG  :
                      in_rgn(i_addr, SMP_BASE,  SMP_LIM)  ? RGN_SMP  :
                      in_rgn(i_addr, PROM_BASE, PROM_LIM) ? RGN_PROM : RGN_NONE;
endmodule

// File: rtl/cclimb_rom_loader.sv
// cclimb_rom_loader: validates an HPS ROM download and forwards accepted bytes to the core ROM port
module cclimb_rom_loader #(
    parameter int unsigned ROM_SIZE = 16'h9060,
    parameter bit          CKSUM_EN = 1'b1
) (
    input  logic                clk_sys,
    input  logic                reset_n,
    cclimb_rom_loader_if.slave  bus,
    output logic                core_reset,
    output logic                rom_ready,
    output logic                rom_error,
    output logic [15:0]         rom_cksum
);
    import cclimb_pkg::*;
    state_t      r_state;
    state_t      w_next;
    logic        r_dl_q;
    logic        r_block;
    logic [16:0] r_cnt;
    logic        r_ovf;
    logic        w_rise;
    logic        w_fall;
    logic        w_load;
    logic        w_in_rng;
    logic        w_acc;
    logic        w_drop;
    logic        w_image_ok;
    logic [16:0] w_cnt_inc;
    logic [16:0] w_cnt_next;
    region_t     w_region;

    assign w_rise     = bus.ioctl_download & ~r_dl_q & ~r_block;
    assign w_fall     = ~bus.ioctl_download & r_dl_q;
    assign w_load     = r_state == ST_LOAD;
    assign w_in_rng   = 32'(bus.ioctl_addr) < ROM_SIZE;
    assign w_acc      = w_load & bus.ioctl_wr & w_in_rng;
    assign w_drop     = w_load & bus.ioctl_wr & ~w_in_rng;
    assign w_cnt_inc  = &r_cnt ? r_cnt : r_cnt + 17'd1;
    assign w_cnt_next = w_acc ? w_cnt_inc : r_cnt;
    assign w_image_ok = (32'(w_cnt_next) == ROM_SIZE) & ~(r_ovf | w_drop);

    cclimb_region_dec u_dec (
        .i_addr   (bus.ioctl_addr[15:0]),
        .o_region (w_region)
    );

    // FSM state register
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) r_state <= ST_IDLE;
        else          r_state <= w_next;
    end

    // next state (a write on the falling edge is already in w_cnt_next) and status outputs
    always_comb begin
        w_next     = w_load ? (w_fall ? (w_image_ok ? ST_DONE : ST_ERROR) : r_state)
                            : (w_rise ? ST_LOAD : r_state);
        core_reset = r_state != ST_DONE;
        rom_ready  = r_state == ST_DONE;
        rom_error  = r_state == ST_ERROR;
    end

    // download edge detect; r_block masks a download that is already high when reset releases
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_dl_q  <= 1'b0;
            r_block <= 1'b1;
        end else begin
            r_dl_q  <= bus.ioctl_download;
            r_block <= r_block & bus.ioctl_download;
        end
    end

    // saturating byte counter and sticky oversize flag, cleared when a download starts
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
            r_ovf <= 1'b0;
        end else if (w_rise && !w_load) begin
            r_cnt <= '0;
            r_ovf <= 1'b0;
        end else begin
            r_cnt <= w_cnt_next;
            r_ovf <= r_ovf | w_drop;
        end
    end

    generate
        if (CKSUM_EN) begin : g_cksum
            logic [15:0] r_cksum;
            // running sum of accepted bytes, cleared when a download starts
            always_ff @(posedge clk_sys or negedge reset_n) begin
                if (!reset_n)                r_cksum <= '0;
                else if (w_rise && !w_load)  r_cksum <= '0;
                else if (w_acc)              r_cksum <= r_cksum + {8'd0, bus.ioctl_dout};
            end
            assign rom_cksum = r_cksum;
        end else begin : g_no_cksum
            assign rom_cksum = 16'd0;
        end
    endgenerate

    // registered core ROM write port; region only shown alongside a write
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            bus.dn_wr     <= 1'b0;
            bus.dn_region <= RGN_NONE;
            bus.dn_addr   <= '0;
            bus.dn_data   <= '0;
        end else begin
            bus.dn_wr     <= w_acc;
            bus.dn_region <= w_acc ? w_region : RGN_NONE;
            if (w_acc) begin
                bus.dn_addr <= bus.ioctl_addr[15:0];
                bus.dn_data <= bus.ioctl_dout;
            end
        end
    end
endmodule
